// File: rtl/fpu_flip_pkg.sv
// Shared defaults and helpers for the FPU flip-buffer link.
package fpu_flip_pkg;

  localparam int FLIP_DEPTH_DEF = 4;
  localparam int FLIP_WIDTH_DEF = 32;

  // Occupancy type for the default depth: one extra bit so "full" is representable.
  typedef logic [$clog2(FLIP_DEPTH_DEF):0] flip_cnt_t;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int flip_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/out_flip_ram.sv
// DEPTH x WIDTH storage for out_flip_tx: one synchronous write port,
// one asynchronous read port, no reset on the array.
module out_flip_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the accepted word at the write pointer.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/out_flip_tx.sv
// Transmit-side result buffer: queues FPU results in a DEPTH-entry FIFO and
// launches one word per cycle on out_en/d_out while the receiver's pause is low.
// Optional macro OUT_FLIP_BYPASS_EN: an empty FIFO forwards src_data straight
// to d_out on the same edge (1-cycle latency, no FIFO write).
module out_flip_tx
  import fpu_flip_pkg::*;
#(
  parameter int WIDTH = FLIP_WIDTH_DEF,
  parameter int DEPTH = FLIP_DEPTH_DEF,
  parameter int SLACK = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   src_en,
  input  logic [WIDTH-1:0]       src_data,
  output logic                   src_stall,
  input  logic                   pause_in,
  output logic                   out_en,
  output logic [WIDTH-1:0]       d_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = flip_ptr_w(DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_C = CW'(DEPTH - SLACK);

  logic [PW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_en_q, out_en_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] rd_data;
  logic             launch, accept, bypass;

  out_flip_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wptr_q),
    .wdata_i (src_data),
    .raddr_i (rptr_q),
    .rdata_o (rd_data)
  );

  // Launch/accept decisions and next-state for pointers, count, output and ovf.
  always_comb begin
    launch = (count_q != '0) && !pause_in;
`ifdef OUT_FLIP_BYPASS_EN
    bypass = (count_q == '0) && src_en && !pause_in;
`else
    bypass = 1'b0;
`endif
    // A launch on the same edge frees a slot, so a full FIFO can still accept.
    accept = src_en && !bypass && ((count_q < FULL_C) || launch);

    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    count_d  = count_q;
    out_en_d = 1'b0;
    d_out_d  = d_out_q;
    ovf_d    = ovf_q;

    if (launch) begin
      d_out_d  = rd_data;
      out_en_d = 1'b1;
      rptr_d   = rptr_q + PW'(1);
    end else if (bypass) begin
      d_out_d  = src_data;
      out_en_d = 1'b1;
    end

    if (accept) wptr_d = wptr_q + PW'(1);
    if (src_en && !accept && !bypass) ovf_d = 1'b1;

    case ({accept, launch})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; asynchronous reset discards all queued entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      out_en_q <= 1'b0;
      d_out_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      out_en_q <= out_en_d;
      d_out_q  <= d_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign src_stall = (count_q >= STALL_C);
  assign out_en    = out_en_q;
  assign d_out     = d_out_q;
  assign count     = count_q;
  assign ovf       = ovf_q;

endmodule
